fifo_push_arbiter: RTL and testbench

- Shares the single push port of the parity-checked FIFO between N_REQ producers.
- Uses round-robin ownership with a bounded burst length per owner.
- Appends the parity bit that the FIFO's pop-side checker expects.
- Sits directly in front of the FIFO's push_data_i/push_valid_i/push_grant_o interface.

---
 rtl/fifo_arb_pkg.sv | 25 ++
 rtl/rr_arb_pick.sv | 31 +++
 rtl/fifo_push_arbiter.sv | 142 ++++++++++++++
 tb/tb_fifo_push_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO push-port arbiter.
//   state_t      : arbiter FSM states (IDLE / LOCKED)
//   parity_of()  : parity bit appended to the FIFO word (even or odd sense)
//   owner_w_of() : owner index width for a given requester count
package fifo_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Widest payload parity_of() accepts; narrower payloads are zero-extended,
    // which leaves the reduction XOR unchanged.
    localparam int PAR_MAX_W = 1024;

    function automatic logic parity_of(input logic [PAR_MAX_W-1:0] payload,
                                       input logic                 even_odd);
        return (^payload) ^ even_odd;
    endfunction

    function automatic int owner_w_of(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Cyclic priority search: returns the first set bit of i_req at or after
// i_start, wrapping around. Purely combinational.
//   i_req   : request vector
//   i_start : index with highest priority
//   o_found : any request set
//   o_idx   : winning index (0 when nothing is found)
module rr_arb_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_start,
    output logic          o_found,
    output logic [IW-1:0] o_idx
);

    always_comb begin
        int c;
        c       = 0;
        o_found = |i_req;
        o_idx   = '0;
        // Walk from the lowest priority upward so the closest hit to
        // i_start is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            c = int'(i_start) + i;
            if (c >= N) c = c - N;
            if (i_req[c]) o_idx = IW'(c);
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Shares the single push port of the parity-checked FIFO between N_REQ
// producers. Round-robin ownership, at most MAX_BURST transfers per
// ownership, parity bit appended in bit 0 of the FIFO word.
//   clk, rst       : clock, synchronous active-high reset
//   req_valid_i    : per-requester valid
//   req_data_i     : payloads, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   req_grant_o    : one-hot, transfer for requester k this cycle
//   push_data_o    : {payload, parity} to FIFO push_data_i
//   push_valid_o   : to FIFO push_valid_i
//   push_grant_i   : from FIFO push_grant_o
//   owner_o        : current owner index
//   xfer_count_o   : total accepted transfers (wraps)
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    parameter int  N_REQ      = 4,
    parameter int  MAX_BURST  = 4,
    parameter bit  EVEN_ODD   = 1'b0,
    localparam int OWNER_W    = owner_w_of(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [N_REQ-1:0]            req_grant_o,
    output logic [DATA_WIDTH:0]         push_data_o,
    output logic                        push_valid_o,
    input  logic                        push_grant_i,
    output logic [OWNER_W-1:0]          owner_o,
    output logic [15:0]                 xfer_count_o
);

    state_t                r_state,      w_state_nxt;
    logic [OWNER_W-1:0]    r_owner,      w_owner_nxt;
    logic [OWNER_W-1:0]    r_rr_ptr,     w_rr_ptr_nxt;
    logic [7:0]            r_burst_cnt,  w_burst_nxt;
    logic [15:0]           r_xfer_count, w_xfer_nxt;

    logic [OWNER_W-1:0]    w_owner_inc;
    logic [OWNER_W-1:0]    w_start;
    logic [OWNER_W-1:0]    w_win;
    logic                  w_found;
    logic [DATA_WIDTH-1:0] w_own_data;
    logic                  w_own_vld;
    logic                  w_locked;
    logic                  w_xfer;
    logic                  w_release;

    // Owner's lane selected by compare rather than a variable part-select so
    // an unused owner code (non-power-of-two N_REQ) reads as zero.
    always_comb begin
        w_own_data = '0;
        w_own_vld  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (r_owner == OWNER_W'(k)) begin
                w_own_data = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                w_own_vld  = req_valid_i[k];
            end
        end
    end

    assign w_owner_inc = (r_owner == OWNER_W'(N_REQ - 1)) ? '0 : r_owner + 1'b1;

    // While locked, search starts one past the owner, so the old owner can
    // only re-win when it is the sole requester.
    assign w_start = (r_state == LOCKED) ? w_owner_inc : r_rr_ptr;

    rr_arb_pick #(
        .N  (N_REQ),
        .IW (OWNER_W)
    ) u_pick (
        .i_req   (req_valid_i),
        .i_start (w_start),
        .o_found (w_found),
        .o_idx   (w_win)
    );

    // rst gates the combinational outputs so no grant escapes in a reset cycle.
    assign w_locked  = (r_state == LOCKED) && !rst;
    assign w_xfer    = w_locked && w_own_vld && push_grant_i;
    assign w_release = (r_state == LOCKED) &&
                       (!w_own_vld || (w_xfer && r_burst_cnt == 8'(MAX_BURST - 1)));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_owner      <= '0;
            r_rr_ptr     <= '0;
            r_burst_cnt  <= '0;
            r_xfer_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_burst_cnt  <= w_burst_nxt;
            r_xfer_count <= w_xfer_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_rr_ptr_nxt = r_rr_ptr;
        w_burst_nxt  = w_xfer ? r_burst_cnt + 8'd1 : r_burst_cnt;
        w_xfer_nxt   = r_xfer_count + 16'(w_xfer);
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = LOCKED;
                    w_owner_nxt = w_win;
                    w_burst_nxt = '0;
                end
            end
            LOCKED: begin
                if (w_release) begin
                    w_rr_ptr_nxt = w_owner_inc;
                    w_burst_nxt  = '0;
                    if (w_found) w_owner_nxt = w_win;
                    else         w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        push_valid_o = w_locked && w_own_vld;
        push_data_o  = '0;
        if (w_locked)
            push_data_o = {w_own_data, parity_of(PAR_MAX_W'(w_own_data), EVEN_ODD)};
        req_grant_o  = '0;
        for (int k = 0; k < N_REQ; k++)
            req_grant_o[k] = w_xfer && (r_owner == OWNER_W'(k));
        owner_o      = r_owner;
        xfer_count_o = r_xfer_count;
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
module tb_fifo_push_arbiter;
    localparam int DW = 32;
    localparam int NR = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req_valid_i = '0;
    logic [NR*DW-1:0] req_data_i = '0;
    logic [NR-1:0]   req_grant_o;
    logic [DW:0]     push_data_o;
    logic            push_valid_o;
    logic            push_grant_i = 1'b1;
    logic [1:0]      owner_o;
    logic [15:0]     xfer_count_o;

    int total = 0;
    int bad   = 0;

    // Expected FIFO words: 0x7 has odd weight -> parity 1; 0x3 even -> 0;
    // 0x80000000 odd -> 1.
    logic [DW:0] exp_word [NR];

    always #5 clk = ~clk;

    fifo_push_arbiter #(
        .DATA_WIDTH (DW),
        .N_REQ      (NR),
        .MAX_BURST  (4),
        .EVEN_ODD   (1'b0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_data_i   (req_data_i),
        .req_grant_o  (req_grant_o),
        .push_data_o  (push_data_o),
        .push_valid_o (push_valid_o),
        .push_grant_i (push_grant_i),
        .owner_o      (owner_o),
        .xfer_count_o (xfer_count_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        exp_word[0] = 33'h00000000F;
        exp_word[1] = 33'h000000006;
        exp_word[2] = 33'h100000001;
        req_data_i  = {32'h80000000, 32'h00000003, 32'h00000007};

        // Reset with everyone requesting and the FIFO ready
        rst = 1'b1; req_valid_i = 3'b111; push_grant_i = 1'b1;
        #2;
        chk("rst0_pv",  64'(push_valid_o), 64'd0);
        chk("rst0_gnt", 64'(req_grant_o),  64'd0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("rst_pv",    64'(push_valid_o), 64'd0);
            chk("rst_gnt",   64'(req_grant_o),  64'd0);
            chk("rst_cnt",   64'(xfer_count_o), 64'd0);
            chk("rst_owner", 64'(owner_o),      64'd0);
        end
        rst = 1'b0;
        chk("idle_pv", 64'(push_valid_o), 64'd0);
        cyc();

        // Round robin: 4 each for 0,1,2 then back to 0
        for (int i = 0; i < 13; i++) begin
            chk("rr_gnt",  64'(req_grant_o),  64'(3'b001 << ((i / 4) % 3)));
            chk("rr_data", 64'(push_data_o),  64'(exp_word[(i / 4) % 3]));
            chk("rr_cnt",  64'(xfer_count_o), 64'(i));
            cyc();
        end

        // Single requester re-wins with no bubble
        do_reset();
        req_valid_i = 3'b010;
        cyc();
        for (int i = 0; i < 6; i++) begin
            chk("one_gnt",   64'(req_grant_o), 64'(3'b010));
            chk("one_owner", 64'(owner_o),     64'd1);
            chk("one_data",  64'(push_data_o), 64'h000000006);
            cyc();
        end
        chk("one_cnt", 64'(xfer_count_o), 64'd6);
        req_data_i[DW +: DW] = 32'h00000001;
        #1;
        chk("one_par", 64'(push_data_o), 64'h000000003);
        req_data_i[DW +: DW] = 32'h00000003;

        // Backpressure on owner 2 after its first transfer
        do_reset();
        req_valid_i = 3'b111;
        cyc();
        repeat (9) cyc();
        chk("bp_owner0", 64'(owner_o), 64'd2);
        push_grant_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_gnt",   64'(req_grant_o),  64'd0);
            chk("bp_owner", 64'(owner_o),      64'd2);
            chk("bp_data",  64'(push_data_o),  64'(exp_word[2]));
            chk("bp_pv",    64'(push_valid_o), 64'd1);
            cyc();
        end
        push_grant_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_resume", 64'(req_grant_o), 64'(3'b100));
            cyc();
        end
        chk("bp_release", 64'(req_grant_o), 64'(3'b001));

        // Early drop by owner 0 after two transfers
        do_reset();
        req_valid_i = 3'b011;
        cyc();
        chk("drop_g1", 64'(req_grant_o), 64'(3'b001));
        cyc();
        chk("drop_g2", 64'(req_grant_o), 64'(3'b001));
        cyc();
        req_valid_i = 3'b010;
        #1;
        chk("drop_pv",  64'(push_valid_o), 64'd0);
        chk("drop_gnt", 64'(req_grant_o),  64'd0);
        cyc();
        chk("drop_owner", 64'(owner_o),     64'd1);
        chk("drop_next",  64'(req_grant_o), 64'(3'b010));

        // Transfer counter wrap, then reset mid-burst
        do_reset();
        req_valid_i = 3'b001;
        cyc();
        force dut.r_xfer_count = 16'hFFFE;
        #1;
        release dut.r_xfer_count;
        #1;
        chk("wrap_pre", 64'(xfer_count_o), 64'hFFFE);
        cyc();
        chk("wrap_ffff", 64'(xfer_count_o), 64'hFFFF);
        cyc();
        chk("wrap_0000", 64'(xfer_count_o), 64'h0000);
        cyc();
        chk("wrap_0001", 64'(xfer_count_o), 64'h0001);
        rst = 1'b1;
        #1;
        chk("mid_rst_gnt", 64'(req_grant_o),  64'd0);
        chk("mid_rst_pv",  64'(push_valid_o), 64'd0);
        cyc();
        chk("mid_rst_owner", 64'(owner_o),      64'd0);
        chk("mid_rst_cnt",   64'(xfer_count_o), 64'd0);
        rst = 1'b0;
        cyc();
        chk("post_rst_gnt", 64'(req_grant_o), 64'(3'b001));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
